median_seq: RTL and testbench



---
 rtl/median_seq_pkg.sv | 22 ++
 rtl/median_seq_if.sv | 21 ++
 rtl/median_seq_mce.sv | 22 ++
 rtl/median_seq.sv | 137 +++++++++++++
 tb/tb_median_seq.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/median_seq_pkg.sv
// Shared types and constants for the median_seq 3x3 median filter stage.
// Optional feature macro used across the slice: MEDIAN_SEQ_ERR_EN.
package median_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PASS,
    ST_FINAL,
    ST_DONE
  } med_state_e;

  localparam int MED_TAPS   = 9;
  localparam int MED_PASSES = 4;
  localparam int MED_FINAL  = 4;

  // Pass p compares over 8-p cycles; the top p+1 ring slots are already sorted.
  function automatic logic [3:0] cmp_cycles(input logic [2:0] p);
    return 4'(MED_TAPS - 1) - {1'b0, p};
  endfunction

endpackage

// File: rtl/median_seq_if.sv
// Pixel-in / median-out bundle for median_seq; ERR exists only with MEDIAN_SEQ_ERR_EN.
// master = upstream serializer side, slave = the filter stage.
interface median_seq_if #(parameter int WIDTH = 8);

  logic [WIDTH-1:0] DI;
  logic             DSI;
  logic [WIDTH-1:0] DO;
  logic             DSO;
  logic             BUSY;

`ifdef MEDIAN_SEQ_ERR_EN
  logic             ERR;

  modport master (output DI, DSI, input DO, DSO, BUSY, ERR);
  modport slave  (input DI, DSI, output DO, DSO, BUSY, ERR);
`else
  modport master (output DI, DSI, input DO, DSO, BUSY);
  modport slave  (input DI, DSI, output DO, DSO, BUSY);
`endif

endinterface

// File: rtl/median_seq_mce.sv
// mce: combinational unsigned MAX/MIN comparator used by the median_seq ring.
// Ties resolve to a, which keeps duplicate pixels intact.
module mce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] max_o,
  output logic [WIDTH-1:0] min_o
);

  always_comb begin
    if (a_i >= b_i) begin
      max_o = a_i;
      min_o = b_i;
    end else begin
      max_o = b_i;
      min_o = a_i;
    end
  end

endmodule

// File: rtl/median_seq.sv
// median_seq: 9-tap circular comparator ring plus control FSM producing a 3x3 median.
// Define MEDIAN_SEQ_ERR_EN to add the sticky protocol-error flag ERR.
module median_seq
  import median_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  median_seq_if.slave bus
);

  med_state_e       state_q;
  logic [3:0]       cnt_q;
  logic [2:0]       pass_q;
  logic             dso_q;
  logic [WIDTH-1:0] ring_q [MED_TAPS];

  logic [WIDTH-1:0] head_d;
  logic [WIDTH-1:0] tail_d;
  logic [WIDTH-1:0] cmpB;
  logic [WIDTH-1:0] maxV;
  logic [WIDTH-1:0] minV;
  logic             loadSel;
  logic             bypass;
  logic             start;

  assign start = bus.DSI && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    loadSel = 1'b0;
    bypass  = 1'b0;
    case (state_q)
      ST_PASS:  bypass = (cnt_q >= cmp_cycles(pass_q));
      ST_FINAL: bypass = 1'b0;
      default: begin
        loadSel = 1'b1;
        bypass  = 1'b1;
      end
    endcase
  end

  // In bypass both operands are the tail, so MIN hands the old tail to the head losslessly.
  assign cmpB = bypass ? ring_q[MED_TAPS-1] : ring_q[MED_TAPS-2];

  mce #(.WIDTH(WIDTH)) u_mce (
    .a_i   (ring_q[MED_TAPS-1]),
    .b_i   (cmpB),
    .max_o (maxV),
    .min_o (minV)
  );

  assign head_d = loadSel ? bus.DI : minV;
  assign tail_d = bypass ? ring_q[MED_TAPS-2] : maxV;

  always_ff @(posedge clk) begin
    ring_q[0] <= head_d;
    for (int i = 1; i < MED_TAPS - 1; i++) begin
      ring_q[i] <= ring_q[i-1];
    end
    ring_q[MED_TAPS-1] <= tail_d;
  end

  // Load cycle 0 happens in IDLE/DONE, so LOAD itself only spans the remaining 8 cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pass_q  <= '0;
      dso_q   <= 1'b0;
    end else begin
      dso_q <= 1'b0;
      cnt_q <= cnt_q + 4'd1;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          cnt_q   <= '0;
          pass_q  <= '0;
          state_q <= start ? ST_LOAD : ST_IDLE;
        end
        ST_LOAD: begin
          if (cnt_q == 4'(MED_TAPS - 2)) begin
            state_q <= ST_PASS;
            cnt_q   <= '0;
            pass_q  <= '0;
          end
        end
        ST_PASS: begin
          if (cnt_q == 4'(MED_TAPS - 1)) begin
            cnt_q <= '0;
            if (pass_q == 3'(MED_PASSES - 1)) begin
              state_q <= ST_FINAL;
              pass_q  <= '0;
            end else begin
              pass_q <= pass_q + 3'd1;
            end
          end
        end
        ST_FINAL: begin
          if (cnt_q == 4'(MED_FINAL - 1)) begin
            state_q <= ST_DONE;
            cnt_q   <= '0;
            pass_q  <= '0;
            dso_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          pass_q  <= '0;
        end
      endcase
    end
  end

  assign bus.DO   = ring_q[MED_TAPS-1];
  assign bus.DSO  = dso_q;
  assign bus.BUSY = (state_q == ST_LOAD) || (state_q == ST_PASS) || (state_q == ST_FINAL) ||
                    ((state_q == ST_IDLE) && bus.DSI);

`ifdef MEDIAN_SEQ_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (start) begin
      err_q <= 1'b0;
    end else if (((state_q == ST_LOAD) && !bus.DSI) ||
                 (((state_q == ST_PASS) || (state_q == ST_FINAL)) && bus.DSI)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.ERR = err_q;
`endif

endmodule

// File: tb/tb_median_seq.sv
// Directed self-checking bench for median_seq; ERR checks compile in with MEDIAN_SEQ_ERR_EN.
// Each test task drives a cycle-indexed sequence and compares against hand-computed medians.
module tb_median_seq;

  typedef logic [7:0] win_t [9];

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  median_seq_if #(.WIDTH(8)) bus ();

  median_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int         nChecks = 0;
  int         nFails  = 0;
  int         dsoCyc[$];
  logic [7:0] dsoVal[$];
  logic       busyLog [200];
  logic       errLog  [200];

  // Cycle t: inputs change mid-cycle on the falling edge, outputs sampled 1 time unit later.
  task automatic run_seq(input win_t wa, input win_t wb, input int startB, input int holdHigh,
                         input int lowAt, input int pulseAt, input int rstAt, input int nCycles);
    dsoCyc.delete();
    dsoVal.delete();
    for (int t = 0; t < nCycles; t++) begin
      logic [7:0] di;
      logic       dsi;
      di  = 8'd0;
      dsi = 1'b0;
      if (t < 9) begin
        dsi = 1'b1;
        di  = wa[t];
      end
      if ((startB >= 0) && (t >= startB) && (t < startB + 9)) begin
        dsi = 1'b1;
        di  = wb[t - startB];
      end
      if (t < holdHigh) dsi = 1'b1;
      if (t == lowAt) begin
        dsi = 1'b0;
        di  = 8'd0;
      end
      if (t == pulseAt) dsi = 1'b1;
      @(negedge clk);
      bus.DI  = di;
      bus.DSI = dsi;
      rst     = (t == rstAt);
      #1;
      busyLog[t] = bus.BUSY;
`ifdef MEDIAN_SEQ_ERR_EN
      errLog[t] = bus.ERR;
`else
      errLog[t] = 1'b0;
`endif
      if (bus.DSO === 1'b1) begin
        dsoCyc.push_back(t);
        dsoVal.push_back(bus.DO);
      end
    end
    @(negedge clk);
    bus.DSI = 1'b0;
    bus.DI  = 8'd0;
    rst     = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    bus.DSI = 1'b0;
    bus.DI  = 8'd0;
    repeat (3) @(negedge clk);
    #1;
    nChecks++;
    if (bus.DSO !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_dso: got %b expected 0", bus.DSO);
    end
    nChecks++;
    if (bus.BUSY !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_busy: got %b expected 0", bus.BUSY);
    end
`ifdef MEDIAN_SEQ_ERR_EN
    nChecks++;
    if (bus.ERR !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_err: got %b expected 0", bus.ERR);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    win_t w;
    int   busyBad;
    w = '{8'd10, 8'd90, 8'd30, 8'd70, 8'd50, 8'd20, 8'd80, 8'd40, 8'd60};
    run_seq(w, w, -1, 0, -1, -1, -1, 60);
    nChecks++;
    if (dsoCyc.size() !== 1) begin
      nFails++;
      $display("[TB] FAIL basic_dso_count: got %0d expected 1", dsoCyc.size());
    end
    if (dsoCyc.size() >= 1) begin
      nChecks++;
      if (dsoCyc[0] !== 49) begin
        nFails++;
        $display("[TB] FAIL basic_dso_cycle: got %0d expected 49", dsoCyc[0]);
      end
      nChecks++;
      if (dsoVal[0] !== 8'd50) begin
        nFails++;
        $display("[TB] FAIL basic_median: got %0d expected 50", dsoVal[0]);
      end
    end
    busyBad = 0;
    for (int t = 0; t < 60; t++) begin
      if (busyLog[t] !== (t <= 48)) busyBad++;
    end
    nChecks++;
    if (busyBad !== 0) begin
      nFails++;
      $display("[TB] FAIL basic_busy_window: got %0d wrong cycles expected 0", busyBad);
    end
`ifdef MEDIAN_SEQ_ERR_EN
    nChecks++;
    if (errLog[48] !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL basic_err_clean: got %b expected 0", errLog[48]);
    end
`endif
  endtask

  task automatic test_saturate();
    win_t w;
    w = '{default: 8'd255};
    run_seq(w, w, -1, 0, -1, -1, -1, 55);
    nChecks++;
    if ((dsoCyc.size() !== 1) || (dsoVal[0] !== 8'd255)) begin
      nFails++;
      $display("[TB] FAIL sat_all255: got count %0d value %0d expected count 1 value 255",
               dsoCyc.size(), (dsoVal.size() > 0) ? dsoVal[0] : 8'd0);
    end
    w = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    run_seq(w, w, -1, 0, -1, -1, -1, 55);
    nChecks++;
    if ((dsoCyc.size() !== 1) || (dsoVal[0] !== 8'd1)) begin
      nFails++;
      $display("[TB] FAIL sat_dup01: got count %0d value %0d expected count 1 value 1",
               dsoCyc.size(), (dsoVal.size() > 0) ? dsoVal[0] : 8'd0);
    end
  endtask

  task automatic test_dsi_in_pass();
    win_t w;
    win_t w2;
    w  = '{8'd12, 8'd200, 8'd45, 8'd45, 8'd99, 8'd3, 8'd150, 8'd77, 8'd61};
    w2 = '{8'd10, 8'd90, 8'd30, 8'd70, 8'd50, 8'd20, 8'd80, 8'd40, 8'd60};
    run_seq(w, w2, 55, 0, -1, 15, -1, 110);
    nChecks++;
    if (dsoCyc.size() !== 2) begin
      nFails++;
      $display("[TB] FAIL pass_dso_count: got %0d expected 2", dsoCyc.size());
    end
    if (dsoCyc.size() >= 2) begin
      nChecks++;
      if ((dsoCyc[0] !== 49) || (dsoVal[0] !== 8'd61)) begin
        nFails++;
        $display("[TB] FAIL pass_first: got cycle %0d value %0d expected cycle 49 value 61",
                 dsoCyc[0], dsoVal[0]);
      end
      nChecks++;
      if ((dsoCyc[1] !== 104) || (dsoVal[1] !== 8'd50)) begin
        nFails++;
        $display("[TB] FAIL pass_second: got cycle %0d value %0d expected cycle 104 value 50",
                 dsoCyc[1], dsoVal[1]);
      end
    end
`ifdef MEDIAN_SEQ_ERR_EN
    nChecks++;
    if ({errLog[15], errLog[16], errLog[55], errLog[56]} !== 4'b0110) begin
      nFails++;
      $display("[TB] FAIL pass_err_seq: got %b%b%b%b expected 0110 (t15,t16,t55,t56)",
               errLog[15], errLog[16], errLog[55], errLog[56]);
    end
`endif
  endtask

  task automatic test_dsi_low_load();
    win_t w;
    w = '{8'd100, 8'd110, 8'd120, 8'd130, 8'd135, 8'd140, 8'd150, 8'd160, 8'd170};
    run_seq(w, w, -1, 0, 4, -1, -1, 55);
    nChecks++;
    if ((dsoCyc.size() !== 1) || (dsoVal[0] !== 8'd130) || (dsoCyc[0] !== 49)) begin
      nFails++;
      $display("[TB] FAIL low_median: got count %0d value %0d expected count 1 value 130 at 49",
               dsoCyc.size(), (dsoVal.size() > 0) ? dsoVal[0] : 8'd0);
    end
`ifdef MEDIAN_SEQ_ERR_EN
    nChecks++;
    if ({errLog[4], errLog[5]} !== 2'b01) begin
      nFails++;
      $display("[TB] FAIL low_err: got %b%b expected 01 (t4,t5)", errLog[4], errLog[5]);
    end
`endif
  endtask

  task automatic test_back_to_back();
    win_t w;
    win_t w2;
    w  = '{8'd10, 8'd90, 8'd30, 8'd70, 8'd50, 8'd20, 8'd80, 8'd40, 8'd60};
    w2 = '{8'd3, 8'd9, 8'd7, 8'd1, 8'd8, 8'd7, 8'd2, 8'd11, 8'd6};
    run_seq(w, w2, 49, 98, -1, -1, -1, 105);
    nChecks++;
    if (dsoCyc.size() !== 2) begin
      nFails++;
      $display("[TB] FAIL b2b_dso_count: got %0d expected 2", dsoCyc.size());
    end
    if (dsoCyc.size() >= 2) begin
      nChecks++;
      if ((dsoCyc[0] !== 49) || (dsoVal[0] !== 8'd50)) begin
        nFails++;
        $display("[TB] FAIL b2b_first: got cycle %0d value %0d expected cycle 49 value 50",
                 dsoCyc[0], dsoVal[0]);
      end
      nChecks++;
      if ((dsoCyc[1] !== 98) || (dsoVal[1] !== 8'd7)) begin
        nFails++;
        $display("[TB] FAIL b2b_second: got cycle %0d value %0d expected cycle 98 value 7",
                 dsoCyc[1], dsoVal[1]);
      end
    end
    nChecks++;
    if (busyLog[50] !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL b2b_busy50: got %b expected 1", busyLog[50]);
    end
  endtask

  task automatic test_reset_mid();
    win_t w;
    win_t w2;
    w  = '{8'd10, 8'd90, 8'd30, 8'd70, 8'd50, 8'd20, 8'd80, 8'd40, 8'd60};
    w2 = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd9, 8'd8, 8'd7, 8'd6};
    run_seq(w, w2, 30, 0, -1, -1, 20, 85);
    nChecks++;
    if (dsoCyc.size() !== 1) begin
      nFails++;
      $display("[TB] FAIL rstmid_dso_count: got %0d expected 1", dsoCyc.size());
    end
    if (dsoCyc.size() >= 1) begin
      nChecks++;
      if ((dsoCyc[0] !== 79) || (dsoVal[0] !== 8'd5)) begin
        nFails++;
        $display("[TB] FAIL rstmid_window: got cycle %0d value %0d expected cycle 79 value 5",
                 dsoCyc[0], dsoVal[0]);
      end
    end
    nChecks++;
    if ({busyLog[20], busyLog[21], busyLog[30]} !== 3'b101) begin
      nFails++;
      $display("[TB] FAIL rstmid_busy: got %b%b%b expected 101 (t20,t21,t30)",
               busyLog[20], busyLog[21], busyLog[30]);
    end
  endtask

  initial begin
    rst     = 1'b1;
    bus.DSI = 1'b0;
    bus.DI  = 8'd0;
    test_reset();
    test_basic();
    test_saturate();
    test_dsi_in_pass();
    test_dsi_low_load();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
